// File: rtl/ring_osc_meas_ctrl_if.sv
// ring_osc_meas_ctrl_if: register-side request/result bus of the ring-oscillator measurement sequencer.
interface ring_osc_meas_ctrl_if #(
    parameter int WIN_W = 16
);
    logic             start;
    logic [WIN_W-1:0] window;
    logic [1:0]       repeats_log2;
    logic             busy;
    logic             valid;
    logic             ready;
    logic [8:0]       result;
    logic             overflow;
    modport master (output start, window, repeats_log2, ready, input busy, valid, result, overflow);
    modport slave  (input start, window, repeats_log2, ready, output busy, valid, result, overflow);
endinterface

// File: rtl/ring_osc_meas_ctrl.sv
// ring_osc_meas_ctrl: arms the ring-oscillator timer, times a counting window, stops it and samples the count.
// Define RO_MEAS_AVG_EN to sum 2^repeats_log2 measurements into result.
module ring_osc_meas_ctrl #(
    parameter int WIN_W       = 16,
    parameter int ARM_CYC     = 2,
    parameter int SYNC_STAGES = 2,
    parameter int SETTLE      = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    ring_osc_meas_ctrl_if.slave        bus,
    output logic                       osc_slow_clk,
    output logic                       osc_enable,
    output logic                       osc_signal,
    input  logic [7:0]                 osc_out
);
    typedef enum logic [2:0] {S_IDLE, S_ARM, S_RUN, S_STOP, S_SETTLE, S_SAMPLE, S_DONE} state_t;

    state_t                           state_q, state_d;
    logic [WIN_W-1:0]                 cnt_q, cnt_d, win_q, win_d, lim;
    logic                             sig_q, sig_d, ovf_q, ovf_d, last, more;
    logic [8:0]                       result_q, result_d;
    logic [SYNC_STAGES-1:0][7:0]      sync_q, sync_d;
    logic [7:0]                       smp;
    logic                             unused_sig;

    assign smp        = sync_q[SYNC_STAGES-1];
    assign unused_sig = smp[7];
    assign lim  = state_q == S_ARM ? WIN_W'(ARM_CYC - 1) :
                  state_q == S_RUN ? win_q - 1'b1 : WIN_W'(SETTLE - 1);
    assign last = cnt_q == lim;

`ifdef RO_MEAS_AVG_EN
    logic [2:0] rep_q, rep_d;  // measurements still to run after the current one
    assign more = rep_q != 3'd0;
    always_comb begin
        rep_d = rep_q;
        if (state_q == S_IDLE && bus.start)
            rep_d = 3'((4'd1 << bus.repeats_log2) - 4'd1);
        else if (state_q == S_SAMPLE && more)
            rep_d = rep_q - 3'd1;
    end
    always_ff @(posedge clk) begin
        if (rst) rep_q <= '0;
        else     rep_q <= rep_d;
    end
`else
    logic unused_k;
    assign more     = 1'b0;
    assign unused_k = ^bus.repeats_log2;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            win_q    <= '0;
            sig_q    <= 1'b0;
            ovf_q    <= 1'b0;
            result_q <= '0;
            sync_q   <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            win_q    <= win_d;
            sig_q    <= sig_d;
            ovf_q    <= ovf_d;
            result_q <= result_d;
            sync_q   <= sync_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (bus.start) state_d = S_ARM;
            S_ARM:    if (last) state_d = S_RUN;
            S_RUN:    if (last) state_d = S_STOP;
            S_STOP:   state_d = S_SETTLE;
            S_SETTLE: if (last) state_d = S_SAMPLE;
            S_SAMPLE: state_d = more ? S_ARM : S_DONE;
            S_DONE:   if (bus.ready) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cnt_d    = state_d != state_q ? '0 : cnt_q + 1'b1;
        win_d    = win_q;
        sig_d    = sig_q;
        ovf_d    = ovf_q;
        result_d = result_q;
        sync_d   = sync_q;
        sync_d[0] = osc_out;
        for (int i = 1; i < SYNC_STAGES; i++) sync_d[i] = sync_q[i-1];
        if (state_q == S_IDLE && bus.start) begin
            win_d    = bus.window == '0 ? WIN_W'(1) : bus.window;
            result_d = '0;
            ovf_d    = 1'b0;
        end
        if (state_q == S_RUN && last) sig_d = ~sig_q;
        if (state_q == S_SAMPLE) begin
            result_d = result_q + {3'b000, smp[5:0]};
            ovf_d    = ovf_q | smp[6];
        end
    end

    always_comb begin
        bus.busy     = state_q != S_IDLE;
        bus.valid    = state_q == S_DONE;
        bus.result   = result_q;
        bus.overflow = ovf_q;
        osc_slow_clk = state_q == S_RUN;
        osc_enable   = state_q != S_IDLE && state_q != S_DONE;
        osc_signal   = sig_q;
    end
endmodule

// File: tb/tb_ring_osc_meas_ctrl.sv
// tb_ring_osc_meas_ctrl: directed bench for ring_osc_meas_ctrl; osc_out is a stub that
// presents the next table entry each time the sequencer toggles osc_signal.
module tb_ring_osc_meas_ctrl;
    logic       clk = 1'b0;
    logic       rst;
    logic       osc_slow_clk, osc_enable, osc_signal;
    logic [7:0] osc_out;
    logic [7:0] stub [4];
    int         tog = 0, base = 0, errors = 0, checks = 0;

    ring_osc_meas_ctrl_if #(.WIN_W(16)) m ();

    ring_osc_meas_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (m),
        .osc_slow_clk (osc_slow_clk),
        .osc_enable   (osc_enable),
        .osc_signal   (osc_signal),
        .osc_out      (osc_out)
    );

    always #5 clk = ~clk;
    always @(osc_signal) tog++;
    assign osc_out = stub[2'(tog - base - 1)];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_meas(input logic [15:0] w, input logic [1:0] k,
                            output int cyc, output int highs, output int rises, output int first);
        logic prev;
        m.window = w; m.repeats_log2 = k; m.ready = 1'b0; m.start = 1'b1;
        tick();
        m.start = 1'b0; m.window = 16'd3; m.repeats_log2 = 2'd0;
        cyc = 0; highs = 0; rises = 0; first = -1; prev = 1'b0;
        while (!m.valid && cyc < 400) begin
            if (osc_slow_clk && !prev) rises++;
            if (osc_slow_clk && first < 0) first = cyc;
            if (osc_slow_clk) highs++;
            prev = osc_slow_clk;
            tick();
            cyc++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        checks++;
        if ({m.busy, m.valid, m.result, m.overflow, osc_slow_clk, osc_enable, osc_signal} !== 15'd0) begin
            errors++;
            $display("FAIL reset_outputs: got busy=%b valid=%b result=%0d ovf=%b slow=%b en=%b sig=%b want all 0",
                     m.busy, m.valid, m.result, m.overflow, osc_slow_clk, osc_enable, osc_signal);
        end
    endtask

    task automatic test_single();
        int cyc, highs, rises, first, t0;
        stub[0] = 8'h2A; base = tog; t0 = tog;
        run_meas(16'd10, 2'd0, cyc, highs, rises, first);
        checks++; if (cyc !== 18) begin errors++; $display("FAIL single_latency: got %0d want 18", cyc); end
        checks++; if (first !== 2) begin errors++; $display("FAIL single_arm_len: got %0d want 2", first); end
        checks++; if (highs !== 10) begin errors++; $display("FAIL single_run_len: got %0d want 10", highs); end
        checks++; if (tog - t0 !== 1) begin errors++; $display("FAIL single_sig_toggles: got %0d want 1", tog - t0); end
        checks++; if (m.result !== 9'd42) begin errors++; $display("FAIL single_result: got %0d want 42", m.result); end
        checks++; if (m.overflow !== 1'b0) begin errors++; $display("FAIL single_ovf: got %b want 0", m.overflow); end
        checks++; if ({m.busy, osc_enable, osc_slow_clk} !== 3'b100) begin errors++; $display("FAIL done_outputs: got %b want 100", {m.busy, osc_enable, osc_slow_clk}); end
        m.ready = 1'b1;
        tick();
        m.ready = 1'b0;
        checks++; if ({m.valid, m.busy, m.result} !== {2'b00, 9'd42}) begin errors++; $display("FAIL single_handshake: got valid=%b busy=%b result=%0d want 0 0 42", m.valid, m.busy, m.result); end
    endtask

    task automatic test_window_zero();
        int cyc, highs, rises, first;
        stub[0] = 8'h01; base = tog;
        run_meas(16'd0, 2'd0, cyc, highs, rises, first);
        checks++; if (cyc !== 9) begin errors++; $display("FAIL win0_latency: got %0d want 9", cyc); end
        checks++; if (highs !== 1) begin errors++; $display("FAIL win0_run_len: got %0d want 1", highs); end
        m.ready = 1'b1; tick(); m.ready = 1'b0;
    endtask

    task automatic test_overflow();
        int cyc, highs, rises, first;
        base = tog;
`ifdef RO_MEAS_AVG_EN
        stub[0] = 8'h05; stub[1] = 8'h47;
        run_meas(16'd4, 2'd1, cyc, highs, rises, first);
        checks++; if (cyc !== 24) begin errors++; $display("FAIL ovf_latency: got %0d want 24", cyc); end
        checks++; if (m.result !== 9'd12) begin errors++; $display("FAIL ovf_result: got %0d want 12", m.result); end
`else
        stub[0] = 8'h47;
        run_meas(16'd4, 2'd0, cyc, highs, rises, first);
        checks++; if (cyc !== 12) begin errors++; $display("FAIL ovf_latency: got %0d want 12", cyc); end
        checks++; if (m.result !== 9'd7) begin errors++; $display("FAIL ovf_result: got %0d want 7", m.result); end
`endif
        checks++; if (m.overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b want 1", m.overflow); end
        m.ready = 1'b1; tick(); m.ready = 1'b0;
    endtask

    task automatic test_avg();
        int cyc, highs, rises, first;
        base = tog;
`ifdef RO_MEAS_AVG_EN
        stub[0] = 8'd10; stub[1] = 8'd20; stub[2] = 8'd30; stub[3] = 8'd40;
        run_meas(16'd10, 2'd2, cyc, highs, rises, first);
        checks++; if (cyc !== 72) begin errors++; $display("FAIL avg_latency: got %0d want 72", cyc); end
        checks++; if (rises !== 4) begin errors++; $display("FAIL avg_pulses: got %0d want 4", rises); end
        checks++; if (m.result !== 9'd100) begin errors++; $display("FAIL avg_result: got %0d want 100", m.result); end
`else
        stub[0] = 8'h3F; stub[1] = 8'h3F; stub[2] = 8'h3F; stub[3] = 8'h3F;
        run_meas(16'd10, 2'd3, cyc, highs, rises, first);
        checks++; if (cyc !== 18) begin errors++; $display("FAIL k_ignored_latency: got %0d want 18", cyc); end
        checks++; if (rises !== 1) begin errors++; $display("FAIL k_ignored_pulses: got %0d want 1", rises); end
        checks++; if (m.result !== 9'd63) begin errors++; $display("FAIL k_ignored_result: got %0d want 63", m.result); end
`endif
        m.ready = 1'b1; tick(); m.ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        int cyc, bad;
        stub[0] = 8'h15; base = tog;
        m.window = 16'd10; m.start = 1'b1;
        tick();
        cyc = 0;
        while (!m.valid && cyc < 400) begin
            m.start = (cyc == 6);
            tick();
            cyc++;
        end
        m.start = 1'b0;
        checks++; if (cyc !== 18) begin errors++; $display("FAIL bp_latency: got %0d want 18", cyc); end
        checks++; if (m.overflow !== 1'b0) begin errors++; $display("FAIL bp_ovf_cleared: got %b want 0", m.overflow); end
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            m.start = (i == 2);
            tick();
            if (m.valid !== 1'b1 || m.result !== 9'd21) bad++;
        end
        m.start = 1'b0;
        checks++; if (bad !== 0) begin errors++; $display("FAIL bp_hold: got %0d bad cycles want 0", bad); end
        m.ready = 1'b1; m.start = 1'b1;
        tick();
        m.ready = 1'b0; m.start = 1'b0;
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            if (m.busy !== 1'b0 || m.valid !== 1'b0 || m.result !== 9'd21) bad++;
            tick();
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL bp_start_ignored: got %0d bad cycles want 0", bad); end
    endtask

    task automatic test_reset_mid_run();
        int cyc, highs, rises, first, seen;
        stub[0] = 8'h2A; base = tog;
        m.window = 16'd10; m.start = 1'b1;
        tick();
        m.start = 1'b0;
        repeat (6) tick();
        checks++; if (osc_slow_clk !== 1'b1) begin errors++; $display("FAIL midrun_in_run: got slow=%b want 1", osc_slow_clk); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if ({m.busy, osc_slow_clk, osc_enable, osc_signal} !== 4'b0000) begin errors++; $display("FAIL midrun_reset: got %b want 0000", {m.busy, osc_slow_clk, osc_enable, osc_signal}); end
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            if (m.valid !== 1'b0 || m.busy !== 1'b0) seen++;
            tick();
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL midrun_no_valid: got %0d active cycles want 0", seen); end
        base = tog;
        run_meas(16'd10, 2'd0, cyc, highs, rises, first);
        checks++; if (cyc !== 18 || m.result !== 9'd42) begin errors++; $display("FAIL midrun_fresh: got cyc=%0d result=%0d want 18 42", cyc, m.result); end
        m.ready = 1'b1; tick(); m.ready = 1'b0;
    endtask

    initial begin
        m.start = 1'b0; m.ready = 1'b0; m.window = '0; m.repeats_log2 = '0;
        for (int i = 0; i < 4; i++) stub[i] = 8'h00;
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        test_reset();
        test_single();
        test_reset();
        test_window_zero();
        test_overflow();
        test_avg();
        test_back_to_back();
        test_reset_mid_run();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/ring_osc_meas_ctrl.md
# ring_osc_meas_ctrl

Sequencer for the ring-oscillator timer macro. It arms the macro, opens a counting window of a programmed number of system clocks, and stops the count by toggling the macro's signal input. It then samples the frozen count through a synchronizer and returns the result over a valid/ready handshake. It sits between the user-project register interface and one ring-oscillator timer instance. Optionally it accumulates 2^K repeated measurements.

## Interface

Parameters:
- `WIN_W`, 16, width of window length.
- `ARM_CYC`, 2, cycles `osc_slow_clk` is held low per measurement. Must be ≥1.
- `SYNC_STAGES`, 2, synchronizer depth on `osc_out`.
- `SETTLE`, 4, wait cycles after stop before sampling. Must be ≥ `SYNC_STAGES`+1.

Ports:
- `clk` in 1: system clock.
- `rst` in 1: reset, synchronous, active-high.
- `start` in 1: request a measurement; sampled only in IDLE.
- `window` in `WIN_W`: counting window in `clk` cycles; 0 is treated as 1.
- `repeats_log2` in 2: K, where repeats = 2^K. Ignored without `RO_MEAS_AVG_EN`.
- `busy` out 1: high in any state other than IDLE.
- `valid` out 1: result available.
- `ready` in 1: consumer accepts the result.
- `result` out 9: count, or sum of counts.
- `overflow` out 1: sticky; set if any sample saw the strobe bit.
- `osc_slow_clk` out 1: macro gate. Low means the macro is armed/reset; high means it counts.
- `osc_enable` out 1: oscillator enable.
- `osc_signal` out 1: macro signal input. Toggled once per measurement to stop the count.
- `osc_out` in 8: macro output. Bit 7 is the saved signal, bit 6 the strobe, bits 5:0 the count low bits. Asynchronous to `clk`.

## Operation

- Reset values: `busy`=0, `valid`=0, `result`=0, `overflow`=0, `osc_slow_clk`=0, `osc_enable`=0, `osc_signal`=0. The FSM is in IDLE and the synchronizer flops are 0.
- FSM states: IDLE, ARM, RUN, STOP, SETTLE, SAMPLE, DONE.
  - IDLE: on `start`=1, capture `window` and K, clear `result` and `overflow`, go to ARM.
  - ARM: `osc_slow_clk`=0 and `osc_enable`=1 for `ARM_CYC` cycles. The latch tracks `osc_signal` and the counter is held reset. Then go to RUN.
  - RUN: `osc_slow_clk`=1 for max(window,1) cycles. Then go to STOP.
  - STOP: 1 cycle. `osc_signal` is inverted on entry, which freezes the macro count.
  - SETTLE: wait `SETTLE` cycles so the synchronized `osc_out` is stable.
  - SAMPLE: 1 cycle.
    - `result` += synced `osc_out[5:0]`, zero-extended.
    - `overflow` |= synced `osc_out[6]`.
    - If repeats remain, go to ARM; otherwise go to DONE.
  - DONE: `valid`=1, `osc_enable`=0, `osc_slow_clk`=0. On `valid`&&`ready`, go to IDLE.
- `osc_signal` is never restored. Each measurement inverts it once, and the next ARM re-latches the current level.
- `osc_enable`=1 only in ARM through SAMPLE.
- Accumulation is unsigned 9-bit: 8 × 63 = 504 fits, so no wrap is possible.

## Timing

- Per-repeat time T = `ARM_CYC` + max(window,1) + 1 + `SETTLE` + 1 cycles.
- `valid` rises T × 2^K cycles after the edge that samples `start` in IDLE. With defaults, window=10 and K=0, that is 18 cycles.
- `result` and `overflow` are stable while `valid`=1. They stay stable after the handshake until the next accepted `start`.
- `start` in any state other than IDLE is ignored. This includes DONE and the handshake cycle itself: a `start` in the cycle where `valid`&&`ready` is ignored.
- `window` and `repeats_log2` changes after acceptance have no effect.
- `rst` asserted in any state: all outputs take their reset values at the next edge. The in-flight measurement is discarded and no `valid` is produced.

## Configuration

- `RO_MEAS_AVG_EN` defined: K is honoured and 2^K samples are summed into `result`.
- `RO_MEAS_AVG_EN` undefined:
  - Exactly one measurement per `start`.
  - `repeats_log2` is unused.
  - `result[8:6]` is always 0.
  - The repeat counter logic is removed.

## Test plan

- Reset: assert `rst` 3 cycles mid-IDLE → all outputs 0 and `osc_slow_clk`=0.
- Single measurement: window=10, K=0, stub `osc_out`=0x2A at sample → `osc_slow_clk` is low 2 cycles then high 10; `osc_signal` toggles once; `valid` at cycle 18; `result`=42; `overflow`=0.
- Averaging (`RO_MEAS_AVG_EN`): K=2, stub counts 10, 20, 30, 40 → four ARM low pulses, `valid` at cycle 72, `result`=100.
- Overflow: stub sets `osc_out[6]`=1 on the second of two samples → `overflow`=1 and `result` still sums bits 5:0.
- Backpressure and ignored start: `ready` low 5 cycles in DONE → `valid` held and `result` unchanged; `start` pulsed during RUN and during DONE → no extra measurement.
- Reset mid-RUN: `rst` at cycle 5 of RUN → next cycle `busy`=0 and `osc_slow_clk`=0; no `valid` ever; a fresh `start` then completes normally.
